// File: rtl/counter_cmd_driver.sv
// counter_cmd_driver: timed command sequencer for universal_counter plus an
// on-chip scoreboard that tracks the value the counter must hold and flags
// any cycle where the counter disagrees.
module counter_cmd_driver #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned LEN_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [LEN_W-1:0] cmd_len,
    output logic [WIDTH-1:0] data,
    output logic             load,
    output logic             incr,
    output logic             pause,
    input  logic [WIDTH-1:0] counter,
    output logic [WIDTH-1:0] expected,
    output logic             busy,
    output logic             done,
    output logic             mismatch,
    output logic [7:0]       err_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_UP   = 2'b01,
        OP_DOWN = 2'b10,
        OP_HOLD = 2'b11
    } op_e;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_e;

    // Command FIFO storage and pointers (extra MSB distinguishes full from empty)
    op_e              op_mem_q   [DEPTH];
    logic [WIDTH-1:0] data_mem_q [DEPTH];
    logic [LEN_W-1:0] len_mem_q  [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    op_e              head_op;
    logic [WIDTH-1:0] head_data;
    logic [LEN_W-1:0] head_len;

    // Sequencer state and registered control outputs
    state_e           state_q, state_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             load_q, load_d;
    logic             incr_q, incr_d;
    logic             pause_q, pause_d;
    logic             done_q, done_d;

    // Checker state
    logic [WIDTH-1:0] expected_q, expected_d;
    logic             check_en_q, check_en_d;
    logic             mismatch_q, mismatch_d;
    logic [7:0]       err_cnt_q, err_cnt_d;
    logic             diverge;

    // FIFO status, head view and handshake
    always_comb begin
        empty     = (wr_ptr_q == rd_ptr_q);
        full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        push      = cmd_valid && !full;
        head_op   = op_mem_q[rd_ptr_q[AW-1:0]];
        head_data = data_mem_q[rd_ptr_q[AW-1:0]];
        head_len  = len_mem_q[rd_ptr_q[AW-1:0]];
        wr_ptr_d  = wr_ptr_q + (push ? PW'(1) : '0);
        rd_ptr_d  = rd_ptr_q + (pop ? PW'(1) : '0);
    end

    // FIFO storage write; contents need no reset since pointers gate validity
    always_ff @(posedge clock) begin
        if (push) begin
            op_mem_q[wr_ptr_q[AW-1:0]]   <= op_e'(cmd_op);
            data_mem_q[wr_ptr_q[AW-1:0]] <= cmd_data;
            len_mem_q[wr_ptr_q[AW-1:0]]  <= cmd_len;
        end
    end

    // Next state, pop decision and control outputs for the active command
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        data_d      = data_q;
        load_d      = load_q;
        incr_d      = incr_q;
        pause_d     = pause_q;
        done_d      = 1'b0;
        pop         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (remaining_q > LEN_W'(1)) begin
                    remaining_d = remaining_q - LEN_W'(1);
                end else if (!empty) begin
                    pop = 1'b1;
                end else begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    load_d  = 1'b0;
                    pause_d = 1'b1;
                    incr_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A pop replaces the active command in the same edge, so commands
        // run back-to-back without an idle cycle between them.
        if (pop) begin
            remaining_d = (head_len == '0) ? LEN_W'(1) : head_len;
            case (head_op)
                OP_LOAD: begin
                    load_d  = 1'b1;
                    pause_d = 1'b0;
                    incr_d  = 1'b1;
                    data_d  = head_data;
                end
                OP_UP: begin
                    load_d  = 1'b0;
                    pause_d = 1'b0;
                    incr_d  = 1'b1;
                end
                OP_DOWN: begin
                    load_d  = 1'b0;
                    pause_d = 1'b0;
                    incr_d  = 1'b0;
                end
                OP_HOLD: begin
                    load_d  = 1'b0;
                    pause_d = 1'b1;
                    incr_d  = 1'b1;
                end
            endcase
        end
    end

    // Reference value follows the controls issued last cycle (load > pause > count)
    always_comb begin
        expected_d = expected_q;
        if (load_q) begin
            expected_d = data_q;
        end else if (!pause_q) begin
            expected_d = incr_q ? (expected_q + WIDTH'(1)) : (expected_q - WIDTH'(1));
        end
        check_en_d = check_en_q | load_q;
        diverge    = check_en_q && (counter != expected_q);
        mismatch_d = mismatch_q | diverge;
        err_cnt_d  = (diverge && (err_cnt_q != 8'hFF)) ? (err_cnt_q + 8'd1) : err_cnt_q;
    end

    // State registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            state_q     <= S_IDLE;
            remaining_q <= '0;
            data_q      <= '0;
            load_q      <= 1'b0;
            incr_q      <= 1'b1;
            pause_q     <= 1'b1;
            done_q      <= 1'b0;
            expected_q  <= '0;
            check_en_q  <= 1'b0;
            mismatch_q  <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            state_q     <= state_d;
            remaining_q <= remaining_d;
            data_q      <= data_d;
            load_q      <= load_d;
            incr_q      <= incr_d;
            pause_q     <= pause_d;
            done_q      <= done_d;
            expected_q  <= expected_d;
            check_en_q  <= check_en_d;
            mismatch_q  <= mismatch_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign cmd_ready = !full;
    assign busy      = (state_q == S_RUN) || !empty;
    assign data      = data_q;
    assign load      = load_q;
    assign incr      = incr_q;
    assign pause     = pause_q;
    assign done      = done_q;
    assign expected  = expected_q;
    assign mismatch  = mismatch_q;
    assign err_cnt   = err_cnt_q;

endmodule
